anc_rst_sequencer: RTL and testbench
====================================

# anc_rst_sequencer

Staged reset and sample-strobe sequencer for the ANC datapath. It consumes the board-level `clk`/`rst` pair and releases the ADC front end and the DSP pipeline from reset in a fixed order, with programmable gaps between stages. Once the sequence completes, it drives the output-enable for the DAC stage and a periodic one-cycle `sample_tick` that clocks the sample-rate logic. A `soft_rst_req` pulse re-runs the whole sequence without a board reset.

## Interface
Parameters:
- `HOLD_CYC`, 16: cycles held in full reset after `rst` deasserts; must be ≥1.
- `STAGE_GAP`, 8: cycles between successive stage releases; must be ≥1.
- `DIV`, 50: `sample_tick` period in `clk` cycles; must be ≥1.
- `CNT_W`, 16: width of the internal counters. `HOLD_CYC`, `STAGE_GAP` and `DIV` must each be < 2^CNT_W.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `soft_rst_req`  in  1  synchronous request to restart the sequence; level-sensitive and sampled every edge.
- `adc_rst_n`  out  1  ADC front-end reset, active-low.
- `dsp_rst_n`  out  1  DSP pipeline reset, active-low.
- `out_en`  out  1  DAC output enable.
- `seq_done`  out  1  high while in the RUN state.
- `sample_tick`  out  1  one-cycle strobe, every `DIV` cycles, in RUN only.
- `state`  out  2  current state encoding.

## Operation
- States: HOLD=0, ADC_UP=1, DSP_UP=2, RUN=3. There is one shared stage counter `cnt` and one divider counter `div_cnt`.
- Reset (`rst`=0 at an edge):
  - state=HOLD, `cnt`=0, `div_cnt`=0.
  - All outputs are 0: `adc_rst_n`, `dsp_rst_n`, `out_en`, `seq_done`, `sample_tick`, `state`.
- HOLD:
  - If `cnt`==HOLD_CYC-1: go to ADC_UP, `cnt`←0, `adc_rst_n`←1.
  - Otherwise `cnt`++.
- ADC_UP:
  - If `cnt`==STAGE_GAP-1: go to DSP_UP, `cnt`←0, `dsp_rst_n`←1.
  - Otherwise `cnt`++.
- DSP_UP:
  - If `cnt`==STAGE_GAP-1: go to RUN, `cnt`←0, `div_cnt`←0, `out_en`←1, `seq_done`←1.
  - Otherwise `cnt`++.
- RUN:
  - If `div_cnt`==DIV-1: `div_cnt`←0 and `sample_tick`←1.
  - Otherwise `div_cnt`++ and `sample_tick`←0.
  - `sample_tick` is 0 in every state other than RUN.
- `soft_rst_req`=1 at an edge (with `rst`=1), in any state:
  - Same effect as reset: state HOLD, counters 0, all outputs 0.
  - The sequence restarts from `cnt`=0 on the first edge where the request is 0.
- Priority: `rst`=0 beats `soft_rst_req`, which beats normal transitions. Both restart actions produce identical register values.
- Held `soft_rst_req`=1 keeps the block in HOLD with `cnt`=0 indefinitely.
- Counters never wrap in stage states; the compare-to-terminal check is the only exit.
- All outputs are registered; none is a combinational function of the inputs.
- Release order is always ADC, then DSP, then out_en. Reset reassertion drops all outputs together.

## Timing
- Edge numbering: edge 1 is the first edge with `rst`=1 and `soft_rst_req`=0.
- `adc_rst_n` rises after edge HOLD_CYC.
- `dsp_rst_n` rises after edge HOLD_CYC+STAGE_GAP.
- `out_en` and `seq_done` rise after edge HOLD_CYC+2·STAGE_GAP; call this edge R.
- `sample_tick` is high after edges R+DIV, R+2·DIV, and so on, each for exactly one cycle.
- DIV=1: `sample_tick` is held high continuously from edge R+1.
- Restart latency: outputs are 0 immediately after the edge that samples `rst`=0 or `soft_rst_req`=1. One cycle of latency, no glitch.
- A restart on the same edge a tick would fire suppresses that tick.
- `state` updates on the same edge as the output that accompanies the transition.

## Test plan
- Power-up, default parameters, `rst` low for 3 edges then high:
  - `adc_rst_n` rises after edge 16, `dsp_rst_n` after 24, `out_en`/`seq_done` after 32.
  - `sample_tick` pulses after edges 82, 132 and 182, one cycle each.
  - `state` reads 0, 1, 2, 3 at the matching edges.
- `soft_rst_req` pulsed for 1 cycle at edge 100 (in RUN):
  - All outputs are 0 after edge 100.
  - `adc_rst_n` rises 16 edges after the request drops; the full sequence repeats.
- `rst` driven low at edge 20 (in ADC_UP):
  - All outputs are 0 after edge 20 and `dsp_rst_n` never rises.
  - After release, `adc_rst_n` rises 16 edges later.
- `soft_rst_req` held high for 40 cycles: state stays 0 and all outputs stay 0 throughout. Release gives the nominal 16/24/32 release timing.
- Restart collision, default parameters: `soft_rst_req` asserted on edge 132 → no tick after edge 132 and all outputs are 0.
- Corner parameters HOLD_CYC=1, STAGE_GAP=1, DIV=1:
  - Releases occur after edges 1, 2 and 3.
  - `sample_tick` is high continuously from edge 4 until the next restart.

Source files
------------

// File: rtl/anc_rst_sequencer.sv
// Staged reset sequencer for the ANC datapath: releases the ADC front end, then the DSP,
// then enables the DAC output and produces a periodic sample strobe.
//
// state   | meaning
// HOLD    | everything held in reset, counting HOLD_CYC cycles
// ADC_UP  | ADC released, counting STAGE_GAP cycles before the DSP is released
// DSP_UP  | DSP released, counting STAGE_GAP cycles before output enable
// RUN     | sequence complete, sample_tick every DIV cycles
module anc_rst_sequencer #(
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned STAGE_GAP = 8,
  parameter int unsigned DIV       = 50,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst_req,
  output logic       adc_rst_n,
  output logic       dsp_rst_n,
  output logic       out_en,
  output logic       seq_done,
  output logic       sample_tick,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_ADC_UP = 2'd1,
    S_DSP_UP = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
  logic             adc_nxt, dsp_nxt, oe_nxt, done_nxt, tick_nxt;

  // Board reset and soft restart clear exactly the same registers.
  always_ff @(posedge clk) begin
    if (!rst || soft_rst_req) begin
      st          <= S_HOLD;
      cnt         <= '0;
      div_cnt     <= '0;
      adc_rst_n   <= 1'b0;
      dsp_rst_n   <= 1'b0;
      out_en      <= 1'b0;
      seq_done    <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      st          <= st_nxt;
      cnt         <= cnt_nxt;
      div_cnt     <= div_cnt_nxt;
      adc_rst_n   <= adc_nxt;
      dsp_rst_n   <= dsp_nxt;
      out_en      <= oe_nxt;
      seq_done    <= done_nxt;
      sample_tick <= tick_nxt;
    end
  end

  always_comb begin
    st_nxt      = st;
    cnt_nxt     = cnt;
    div_cnt_nxt = div_cnt;
    adc_nxt     = adc_rst_n;
    dsp_nxt     = dsp_rst_n;
    oe_nxt      = out_en;
    done_nxt    = seq_done;
    tick_nxt    = 1'b0;
    case (st)
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          st_nxt  = S_ADC_UP;
          cnt_nxt = '0;
          adc_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_ADC_UP: begin
        if (cnt == GAP_LAST) begin
          st_nxt  = S_DSP_UP;
          cnt_nxt = '0;
          dsp_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_DSP_UP: begin
        if (cnt == GAP_LAST) begin
          st_nxt      = S_RUN;
          cnt_nxt     = '0;
          div_cnt_nxt = '0;
          oe_nxt      = 1'b1;
          done_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          tick_nxt    = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + CNT_ONE;
        end
      end
      default: begin
        st_nxt  = S_HOLD;
        cnt_nxt = '0;
      end
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_anc_rst_sequencer.sv
// Self-checking bench for anc_rst_sequencer: directed scenarios plus random restarts,
// checked against an "edges since last restart" model of the release timeline.
module tb_anc_rst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, soft0, rst1, soft1;
  logic       adc0, dsp0, oe0, done0, tick0;
  logic       adc1, dsp1, oe1, done1, tick1;
  logic [1:0] state0, state1;

  int errors = 0;
  int checks = 0;
  int e0 = 0;
  int e1 = 0;

  anc_rst_sequencer dut (
    .clk(clk), .rst(rst0), .soft_rst_req(soft0),
    .adc_rst_n(adc0), .dsp_rst_n(dsp0), .out_en(oe0), .seq_done(done0),
    .sample_tick(tick0), .state(state0)
  );

  anc_rst_sequencer #(.HOLD_CYC(1), .STAGE_GAP(1), .DIV(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst1), .soft_rst_req(soft1),
    .adc_rst_n(adc1), .dsp_rst_n(dsp1), .out_en(oe1), .seq_done(done1),
    .sample_tick(tick1), .state(state1)
  );

  // Expected {state, adc, dsp, out_en, seq_done, tick} after e normal edges since a restart.
  function automatic logic [6:0] exp_vec(int e, int h, int g, int d);
    int r;
    logic [1:0] s;
    logic tk;
    r = h + 2 * g;
    if (e < h) s = 2'd0;
    else if (e < h + g) s = 2'd1;
    else if (e < r) s = 2'd2;
    else s = 2'd3;
    tk = (e > r) && (((e - r) % d) == 0);
    return {s, e >= h, e >= h + g, e >= r, e >= r, tk};
  endfunction

  function automatic logic [6:0] vec0();
    return {state0, adc0, dsp0, oe0, done0, tick0};
  endfunction

  function automatic logic [6:0] vec1();
    return {state1, adc1, dsp1, oe1, done1, tick1};
  endfunction

  task automatic step();
    @(posedge clk);
    e0 = (!rst0 || soft0) ? 0 : e0 + 1;
    e1 = (!rst1 || soft1) ? 0 : e1 + 1;
    @(negedge clk);
  endtask

  task automatic do_reset0();
    rst0 = 1'b0; soft0 = 1'b0;
    step();
    rst0 = 1'b1;
  endtask

  task automatic test_reset();
    rst0 = 1'b0; soft0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (vec0() !== 7'd0) begin
        errors++;
        $display("FAIL reset k=%0d got=%b want=%b", k, vec0(), 7'd0);
      end
    end
  endtask

  task automatic test_power_up();
    int ticks[$];
    rst0 = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      step();
      checks++;
      if (vec0() !== exp_vec(e0, 16, 8, 50)) begin
        errors++;
        $display("FAIL power_up k=%0d got=%b want=%b", k, vec0(), exp_vec(e0, 16, 8, 50));
      end
      if (tick0 === 1'b1) ticks.push_back(k);
      if (k == 15 || k == 16) begin
        checks++;
        if (adc0 !== (k == 16)) begin
          errors++;
          $display("FAIL power_up_adc k=%0d got=%b want=%b", k, adc0, k == 16);
        end
      end
      if (k == 23 || k == 24) begin
        checks++;
        if (dsp0 !== (k == 24)) begin
          errors++;
          $display("FAIL power_up_dsp k=%0d got=%b want=%b", k, dsp0, k == 24);
        end
      end
      if (k == 31 || k == 32) begin
        checks++;
        if ({oe0, done0, state0} !== ((k == 32) ? 4'b1111 : 4'b0010)) begin
          errors++;
          $display("FAIL power_up_run k=%0d got=%b want=%b", k, {oe0, done0, state0},
                   (k == 32) ? 4'b1111 : 4'b0010);
        end
      end
    end
    checks++;
    if (ticks.size() != 3 || ticks[0] != 82 || ticks[1] != 132 || ticks[2] != 182) begin
      errors++;
      $display("FAIL power_up_ticks got=%p want=82,132,182", ticks);
    end
  endtask

  task automatic test_soft_pulse();
    do_reset0();
    for (int k = 1; k <= 160; k++) begin
      soft0 = (k == 100);
      step();
      checks++;
      if (vec0() !== exp_vec(e0, 16, 8, 50)) begin
        errors++;
        $display("FAIL soft_pulse k=%0d got=%b want=%b", k, vec0(), exp_vec(e0, 16, 8, 50));
      end
      if (k == 100 || k == 115 || k == 116) begin
        checks++;
        if (vec0() !== ((k == 116) ? 7'b0110000 : 7'b0000000)) begin
          errors++;
          $display("FAIL soft_pulse_edge k=%0d got=%b want=%b", k, vec0(),
                   (k == 116) ? 7'b0110000 : 7'b0000000);
        end
      end
    end
    soft0 = 1'b0;
  endtask

  task automatic test_rst_mid();
    do_reset0();
    for (int k = 1; k <= 80; k++) begin
      rst0 = (k != 20);
      step();
      checks++;
      if (vec0() !== exp_vec(e0, 16, 8, 50)) begin
        errors++;
        $display("FAIL rst_mid k=%0d got=%b want=%b", k, vec0(), exp_vec(e0, 16, 8, 50));
      end
      if (k >= 16 && k <= 43) begin
        checks++;
        if (dsp0 !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_dsp k=%0d got=%b want=0", k, dsp0);
        end
      end
      if (k == 20 || k == 35 || k == 36) begin
        checks++;
        if (adc0 !== (k == 36)) begin
          errors++;
          $display("FAIL rst_mid_adc k=%0d got=%b want=%b", k, adc0, k == 36);
        end
      end
    end
    rst0 = 1'b1;
  endtask

  task automatic test_soft_held();
    do_reset0();
    soft0 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if (vec0() !== 7'd0) begin
        errors++;
        $display("FAIL soft_held k=%0d got=%b want=%b", k, vec0(), 7'd0);
      end
    end
    soft0 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if ({adc0, dsp0, oe0} !== {k >= 16, k >= 24, k >= 32}) begin
        errors++;
        $display("FAIL soft_release k=%0d got=%b want=%b", k, {adc0, dsp0, oe0},
                 {k >= 16, k >= 24, k >= 32});
      end
    end
  endtask

  task automatic test_collision();
    do_reset0();
    for (int k = 1; k <= 140; k++) begin
      soft0 = (k == 132);
      step();
      checks++;
      if (vec0() !== exp_vec(e0, 16, 8, 50)) begin
        errors++;
        $display("FAIL collision k=%0d got=%b want=%b", k, vec0(), exp_vec(e0, 16, 8, 50));
      end
      if (k == 82 || k == 132) begin
        checks++;
        if (vec0() !== ((k == 82) ? 7'b1111111 : 7'b0000000)) begin
          errors++;
          $display("FAIL collision_edge k=%0d got=%b want=%b", k, vec0(),
                   (k == 82) ? 7'b1111111 : 7'b0000000);
        end
      end
    end
    soft0 = 1'b0;
  endtask

  task automatic test_corner();
    rst1 = 1'b0; soft1 = 1'b0;
    step();
    rst1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      soft1 = (k == 12);
      step();
      checks++;
      if (vec1() !== exp_vec(e1, 1, 1, 1)) begin
        errors++;
        $display("FAIL corner k=%0d got=%b want=%b", k, vec1(), exp_vec(e1, 1, 1, 1));
      end
      if (k <= 11) begin
        checks++;
        if ({adc1, dsp1, oe1, tick1} !== {k >= 1, k >= 2, k >= 3, k >= 4}) begin
          errors++;
          $display("FAIL corner_edge k=%0d got=%b want=%b", k, {adc1, dsp1, oe1, tick1},
                   {k >= 1, k >= 2, k >= 3, k >= 4});
        end
      end
    end
    soft1 = 1'b0;
  endtask

  task automatic test_random();
    do_reset0();
    for (int k = 1; k <= 3000; k++) begin
      rst0  = ($urandom_range(0, 199) != 0);
      soft0 = ($urandom_range(0, 149) == 0);
      rst1  = ($urandom_range(0, 49) != 0);
      soft1 = ($urandom_range(0, 29) == 0);
      step();
      checks++;
      if (vec0() !== exp_vec(e0, 16, 8, 50)) begin
        errors++;
        $display("FAIL random_dflt k=%0d got=%b want=%b", k, vec0(), exp_vec(e0, 16, 8, 50));
      end
      checks++;
      if (vec1() !== exp_vec(e1, 1, 1, 1)) begin
        errors++;
        $display("FAIL random_corner k=%0d got=%b want=%b", k, vec1(), exp_vec(e1, 1, 1, 1));
      end
    end
  endtask

  initial begin
    rst0 = 1'b0; soft0 = 1'b0; rst1 = 1'b0; soft1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_power_up();
    test_soft_pulse();
    test_rst_mid();
    test_soft_held();
    test_collision();
    test_corner();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
